trdb_d5m_capture: RTL and testbench
===================================

# trdb_d5m_capture

Parametrised pixel-capture engine for the TRDB_D5M camera daughter board. Samples the sensor's frame-valid, line-valid and pixel-data outputs, with the pixel bus already synchronous to `ul1Clock`. Applies a runtime window and power-of-two decimation, then delivers pixels on a valid/ready stream with start-of-frame and end-of-line markers through an internal FIFO. It sits between the sensor pins and the image-transfer fabric, and supports single-shot and continuous capture.

## Interface
Parameters:
- PIX_IN_W, 12, sensor pixel width
- PIX_OUT_W, 12, output pixel width; must be ≤ PIX_IN_W; output is the PIX_OUT_W MSBs
- COL_W, 12, column counter/config width
- ROW_W, 11, row counter/config width
- FIFO_DEPTH, 16, output FIFO entries; power of two, ≥4

Ports (one clock; reset is synchronous and active-high):
- ul1Clock  in  1  system and pixel clock
- ul1Reset  in  1  synchronous, active-high reset
- ul1Fval  in  1  sensor frame valid
- ul1Lval  in  1  sensor line valid
- ulPixData  in  PIX_IN_W  sensor pixel
- ul1Enable  in  1  capture enable, level
- ul1Continuous  in  1  1 = continuous, 0 = single-shot
- ul1Arm  in  1  single-shot trigger pulse
- ulColStart / ulColCount  in  COL_W  window columns
- ulRowStart / ulRowCount  in  ROW_W  window rows
- ul2Skip  in  2  decimation 2^n in both axes; n=3 treated as n=2
- ulOutData  out  PIX_OUT_W  pixel
- ul1OutValid  out  1  stream valid
- ul1OutReady  in  1  stream ready
- ul1OutSof  out  1  first pixel of frame, qualified by valid
- ul1OutEol  out  1  last pixel of row, qualified by valid
- ul1Busy  out  1  state ≠ IDLE
- ul16FrameCount  out  16  completed frames, wraps
- ul16DropCount  out  16  pixels lost to FIFO full, saturates at 0xFFFF
- ul1Overflow  out  1  sticky; set on the first drop

## Operation
- States:
  - IDLE → WAIT_SOF when ul1Enable and (ul1Continuous or ul1Arm).
  - WAIT_SOF → ACTIVE on an Fval rising edge.
  - ACTIVE → WAIT_SOF on an Fval falling edge if ul1Continuous and ul1Enable; otherwise → IDLE.
  - ul1Enable low in WAIT_SOF → IDLE.
  - ul1Enable low in ACTIVE completes the current frame first.
- The Fval edge-detect register resets to 1. After reset, a frame already in progress is never captured; Fval must go low, then high.
- Window and skip configuration is latched on the Fval rising edge that enters ACTIVE. Changes mid-frame have no effect until the next frame.
- Column counter:
  - Cleared on the Lval rising edge.
  - Increments on every Lval-high cycle; the first pixel of a line is column 0.
- Row counter:
  - Cleared on entering ACTIVE.
  - Increments on each Lval falling edge.
- Pixel accepted iff all of the following hold:
  - Lval is high.
  - colStart ≤ col < colStart+colCount and rowStart ≤ row < rowStart+rowCount (arithmetic one bit wider than the counters, no wrap).
  - The low n bits of (col−colStart) and of (row−rowStart) are zero.
- EOL is set on the accepted pixel at column colStart + (((colCount−1)>>n)<<n).
- SOF is held pending from frame start and attached to the first pixel successfully written to the FIFO.
- FIFO full:
  - The accepted pixel is discarded, along with its EOL.
  - ul16DropCount increments and ul1Overflow sets.
  - A pending SOF stays pending.
- colCount=0 or rowCount=0: no pixels are output and no SOF is emitted; the frame is still counted.
- ul16FrameCount increments on every ACTIVE→exit transition.
- Output handshake:
  - Transfer occurs when ul1OutValid && ul1OutReady.
  - Data, Sof and Eol stay stable while valid && !ready.
  - Valid never drops without a transfer, except on reset.
- Reset, including mid-frame:
  - State → IDLE; FIFO flushed; all counters cleared; ul1Overflow cleared.

## Timing
- Reset values: ulOutData=0, ul1OutValid=0, ul1OutSof=0, ul1OutEol=0, ul1Busy=0, ul16FrameCount=0, ul16DropCount=0, ul1Overflow=0.
- Sensor inputs are registered once.
- Latency is 3 cycles from input sample to ul1OutValid with the FIFO empty: sample at N, register N+1, FIFO write N+2, valid N+3. The FIFO is first-word-fall-through.
- Throughput is 1 pixel/cycle with ready held high. No bubbles are inserted.
- FIFO read and write in the same cycle while full: the write succeeds and nothing is dropped.
- ul1Busy rises the cycle after the IDLE exit. It falls the cycle after an Fval falling edge is registered in single-shot mode.

## Structure
- Package `trdb_d5m_pkg`: state enum (IDLE, WAIT_SOF, ACTIVE); skip-factor type; default width constants; FIFO entry struct {sof, eol, data}.
- Sub-module `trdb_d5m_fifo`:
  - Synchronous first-word-fall-through FIFO, width PIX_OUT_W+2, depth FIFO_DEPTH.
  - Outputs full/empty; pointers one bit wider than the address.

## Test plan
- Full frame, 8×4, window 0/8/0/4, skip 0, ready=1 → 32 pixels. SOF on pixel 0; EOL on pixels 7, 15, 23, 31. FrameCount=1; first valid 3 cycles after the first Lval-high sample.
- Window col 2/4, row 1/2, skip 1 on 8×4 → pixels (r1,c2), (r1,c4) with EOL on c4. Row 2 skipped; row 3 is out of window, so no pixels.
- Ready low throughout a 40-pixel frame, FIFO_DEPTH=16 → 16 held in FIFO, DropCount=24, Overflow=1. After ready rises, exactly 16 transfers follow, SOF on the first.
- Reset asserted with Fval high mid-frame, released still mid-frame → no output for that frame. Capture starts on the next Fval rising edge.
- Single-shot: Arm pulse, 3 sensor frames → only frame 1 captured, Busy=0 afterwards, FrameCount=1. Continuous with Enable dropped mid frame 2 → frame 2 completes, FrameCount=2, then IDLE.

Source files
------------

// File: rtl/trdb_d5m_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trdb_d5m_pkg : shared types and defaults for the D5M capture engine   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package trdb_d5m_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2
  } state_e;

  typedef logic [1:0] skip_t;

  localparam int unsigned DEF_PIX_IN_W   = 12;
  localparam int unsigned DEF_PIX_OUT_W  = 12;
  localparam int unsigned DEF_COL_W      = 12;
  localparam int unsigned DEF_ROW_W      = 11;
  localparam int unsigned DEF_FIFO_DEPTH = 16;

  // Marker bits carried above the pixel data in each FIFO entry {sof, eol, data}.
  typedef struct packed {
    logic sof;
    logic eol;
  } fifo_tag_t;

  // Low-bit mask selecting offsets that must be zero for a given decimation.
  function automatic logic [1:0] skip_mask(input skip_t s);
    case (s)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/trdb_d5m_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trdb_d5m_fifo : synchronous first-word-fall-through FIFO              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trdb_d5m_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]  wr_ptr_q;
  logic [ADDR_W:0]  rd_ptr_q;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  // A simultaneous read frees the slot, so a write into a full FIFO still lands.
  assign w_push = wr_en_i && (!full_o || rd_en_i);
  assign w_pop  = rd_en_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
      if (w_pop)  rd_ptr_q <= rd_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

endmodule
`default_nettype wire

// File: rtl/trdb_d5m_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trdb_d5m_capture : windowed, decimating D5M pixel capture to a stream |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trdb_d5m_capture
  import trdb_d5m_pkg::*;
#(
  parameter int unsigned PIX_IN_W   = DEF_PIX_IN_W,
  parameter int unsigned PIX_OUT_W  = DEF_PIX_OUT_W,
  parameter int unsigned COL_W      = DEF_COL_W,
  parameter int unsigned ROW_W      = DEF_ROW_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 ul1Clock,
  input  logic                 ul1Reset,
  input  logic                 ul1Fval,
  input  logic                 ul1Lval,
  input  logic [PIX_IN_W-1:0]  ulPixData,
  input  logic                 ul1Enable,
  input  logic                 ul1Continuous,
  input  logic                 ul1Arm,
  input  logic [COL_W-1:0]     ulColStart,
  input  logic [COL_W-1:0]     ulColCount,
  input  logic [ROW_W-1:0]     ulRowStart,
  input  logic [ROW_W-1:0]     ulRowCount,
  input  logic [1:0]           ul2Skip,
  output logic [PIX_OUT_W-1:0] ulOutData,
  output logic                 ul1OutValid,
  input  logic                 ul1OutReady,
  output logic                 ul1OutSof,
  output logic                 ul1OutEol,
  output logic                 ul1Busy,
  output logic [15:0]          ul16FrameCount,
  output logic [15:0]          ul16DropCount,
  output logic                 ul1Overflow
);

  localparam int unsigned ENTRY_W = PIX_OUT_W + 2;

  state_e state_q, state_d;
  logic   w_enter, w_exit;

  logic                fval_q, fval_prev_q, lval_q, lval_prev_q;
  logic [PIX_IN_W-1:0] pix_q;
  logic                w_fval_rise, w_fval_fall, w_lval_rise, w_lval_fall;

  logic [COL_W-1:0] col_start_q, col_count_q, col_q;
  logic [ROW_W-1:0] row_start_q, row_count_q, row_q;
  skip_t            skip_q;

  logic [COL_W-1:0] w_col_start, w_col_count, w_col, w_col_off;
  logic [ROW_W-1:0] w_row_start, w_row_count, w_row, w_row_off;
  skip_t            w_skip;
  logic [1:0]       w_mask;
  logic [COL_W:0]   w_col_x, w_cs_x, w_ce_x, w_cc_m1, w_eol_off;
  logic [ROW_W:0]   w_row_x, w_rs_x, w_re_x;
  logic             w_accept, w_eol;

  logic                 s2_valid_q, s2_eol_q, sof_pend_q;
  logic [PIX_OUT_W-1:0] s2_data_q;
  logic [15:0]          frame_cnt_q, drop_cnt_q;
  logic                 overflow_q;

  logic               w_full, w_empty, w_rd, w_push_ok, w_drop;
  fifo_tag_t          w_wr_tag, w_rd_tag;
  logic [ENTRY_W-1:0] w_rd_entry;

  assign w_fval_rise = fval_q & ~fval_prev_q;
  assign w_fval_fall = ~fval_q & fval_prev_q;
  assign w_lval_rise = lval_q & ~lval_prev_q;
  assign w_lval_fall = ~lval_q & lval_prev_q;

  // Frame-valid history resets high so a frame already running at reset is skipped.
  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) begin
      fval_q      <= 1'b1;
      fval_prev_q <= 1'b1;
      lval_q      <= 1'b0;
      lval_prev_q <= 1'b0;
      pix_q       <= '0;
    end else begin
      fval_q      <= ul1Fval;
      fval_prev_q <= fval_q;
      lval_q      <= ul1Lval;
      lval_prev_q <= lval_q;
      pix_q       <= ulPixData;
    end
  end

  always_comb begin
    state_d = state_q;
    w_enter = 1'b0;
    w_exit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ul1Enable && (ul1Continuous || ul1Arm)) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!ul1Enable) begin
          state_d = IDLE;
        end else if (w_fval_rise) begin
          state_d = ACTIVE;
          w_enter = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_fval_fall) begin
          w_exit  = 1'b1;
          state_d = (ul1Continuous && ul1Enable) ? WAIT_SOF : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // The entering cycle sees the live config so a line starting with the frame is not lost.
  assign w_col_start = w_enter ? ulColStart : col_start_q;
  assign w_col_count = w_enter ? ulColCount : col_count_q;
  assign w_row_start = w_enter ? ulRowStart : row_start_q;
  assign w_row_count = w_enter ? ulRowCount : row_count_q;
  assign w_skip      = w_enter ? ul2Skip    : skip_q;
  assign w_mask      = skip_mask(w_skip);

  assign w_col = w_lval_rise ? '0 : col_q;
  assign w_row = w_enter     ? '0 : row_q;

  always_comb begin
    w_col_x   = {1'b0, w_col};
    w_cs_x    = {1'b0, w_col_start};
    w_ce_x    = w_cs_x + {1'b0, w_col_count};
    w_row_x   = {1'b0, w_row};
    w_rs_x    = {1'b0, w_row_start};
    w_re_x    = w_rs_x + {1'b0, w_row_count};
    w_col_off = w_col - w_col_start;
    w_row_off = w_row - w_row_start;
    w_cc_m1   = {1'b0, w_col_count} - {{COL_W{1'b0}}, 1'b1};
    w_eol_off = {w_cc_m1[COL_W:2], w_cc_m1[1:0] & ~w_mask};
    w_eol     = (w_col_x == (w_cs_x + w_eol_off));
    w_accept  = lval_q && ((state_q == ACTIVE) || w_enter) &&
                (w_col_x >= w_cs_x) && (w_col_x < w_ce_x) &&
                (w_row_x >= w_rs_x) && (w_row_x < w_re_x) &&
                ((w_col_off[1:0] & w_mask) == 2'b00) &&
                ((w_row_off[1:0] & w_mask) == 2'b00);
  end

  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) begin
      col_start_q <= '0;
      col_count_q <= '0;
      row_start_q <= '0;
      row_count_q <= '0;
      skip_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      s2_valid_q  <= 1'b0;
      s2_eol_q    <= 1'b0;
      s2_data_q   <= '0;
    end else begin
      if (w_enter) begin
        col_start_q <= ulColStart;
        col_count_q <= ulColCount;
        row_start_q <= ulRowStart;
        row_count_q <= ulRowCount;
        skip_q      <= ul2Skip;
      end
      if (lval_q) col_q <= w_col + {{(COL_W-1){1'b0}}, 1'b1};
      row_q      <= w_row + {{(ROW_W-1){1'b0}}, w_lval_fall};
      s2_valid_q <= w_accept;
      s2_eol_q   <= w_eol;
      s2_data_q  <= pix_q[PIX_IN_W-1 -: PIX_OUT_W];
    end
  end

  assign w_rd      = ul1OutValid && ul1OutReady;
  assign w_push_ok = s2_valid_q && (!w_full || w_rd);
  assign w_drop    = s2_valid_q && w_full && !w_rd;

  // SOF waits for the first pixel that actually lands; dropped pixels leave it pending.
  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) begin
      sof_pend_q  <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (w_enter)        sof_pend_q <= 1'b1;
      else if (w_push_ok) sof_pend_q <= 1'b0;
      if (w_exit) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (w_drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign w_wr_tag.sof = sof_pend_q;
  assign w_wr_tag.eol = s2_eol_q;

  trdb_d5m_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (ul1Clock),
    .rst_i     (ul1Reset),
    .wr_en_i   (s2_valid_q),
    .wr_data_i ({w_wr_tag, s2_data_q}),
    .rd_en_i   (w_rd),
    .rd_data_o (w_rd_entry),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  assign w_rd_tag       = fifo_tag_t'(w_rd_entry[ENTRY_W-1 -: 2]);
  assign ulOutData      = w_rd_entry[PIX_OUT_W-1:0];
  assign ul1OutValid    = !w_empty;
  assign ul1OutSof      = w_rd_tag.sof;
  assign ul1OutEol      = w_rd_tag.eol;
  assign ul1Busy        = (state_q != IDLE);
  assign ul16FrameCount = frame_cnt_q;
  assign ul16DropCount  = drop_cnt_q;
  assign ul1Overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_trdb_d5m_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_trdb_d5m_capture : scoreboard bench for trdb_d5m_capture           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_trdb_d5m_capture;

  localparam int BIG = 1 << 30;

  logic        ul1Clock = 1'b0;
  logic        ul1Reset = 1'b1;
  logic        ul1Fval = 1'b0, ul1Lval = 1'b0;
  logic [11:0] ulPixData = '0;
  logic        ul1Enable = 1'b0, ul1Continuous = 1'b0, ul1Arm = 1'b0;
  logic [11:0] ulColStart = '0, ulColCount = '0;
  logic [10:0] ulRowStart = '0, ulRowCount = '0;
  logic [1:0]  ul2Skip = '0;
  logic [11:0] ulOutData;
  logic        ul1OutValid, ul1OutReady = 1'b1, ul1OutSof, ul1OutEol, ul1Busy, ul1Overflow;
  logic [15:0] ul16FrameCount, ul16DropCount;

  trdb_d5m_capture dut (
    .ul1Clock(ul1Clock), .ul1Reset(ul1Reset), .ul1Fval(ul1Fval), .ul1Lval(ul1Lval),
    .ulPixData(ulPixData), .ul1Enable(ul1Enable), .ul1Continuous(ul1Continuous),
    .ul1Arm(ul1Arm), .ulColStart(ulColStart), .ulColCount(ulColCount),
    .ulRowStart(ulRowStart), .ulRowCount(ulRowCount), .ul2Skip(ul2Skip),
    .ulOutData(ulOutData), .ul1OutValid(ul1OutValid), .ul1OutReady(ul1OutReady),
    .ul1OutSof(ul1OutSof), .ul1OutEol(ul1OutEol), .ul1Busy(ul1Busy),
    .ul16FrameCount(ul16FrameCount), .ul16DropCount(ul16DropCount),
    .ul1Overflow(ul1Overflow)
  );

  always #5 ul1Clock = ~ul1Clock;

  int cyc = 0;
  always @(posedge ul1Clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [11:0] data;
    logic        sof;
    logic        eol;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   exp_fc = 0;
  int   m_cs, m_cc, m_rs, m_rc, m_skip;
  bit   rand_ready = 0;
  bit   lat_armed = 0;
  int   first_lval_edge = -1, first_valid_edge = -1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: window membership, decimation grid and last-column rule.
  function automatic int m_step();
    return 1 << ((m_skip == 3) ? 2 : m_skip);
  endfunction

  function automatic bit m_accept(input int c, input int r);
    int s;
    s = m_step();
    return (c >= m_cs) && (c < m_cs + m_cc) && (r >= m_rs) && (r < m_rs + m_rc) &&
           ((c - m_cs) % s == 0) && ((r - m_rs) % s == 0);
  endfunction

  function automatic bit m_eol(input int c);
    int s;
    s = m_step();
    return c == m_cs + ((m_cc - 1) / s) * s;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ul1Clock);
      #1;
      if (rand_ready) ul1OutReady = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic apply_cfg();
    ulColStart = 12'(m_cs);
    ulColCount = 12'(m_cc);
    ulRowStart = 11'(m_rs);
    ulRowCount = 11'(m_rc);
    ul2Skip    = 2'(m_skip);
  endtask

  task automatic set_cfg(input int cs, input int cc, input int rs, input int rc, input int sk);
    m_cs = cs; m_cc = cc; m_rs = rs; m_rc = rc; m_skip = sk;
    apply_cfg();
  endtask

  // Drives one sensor frame; config inputs are scrambled mid-frame to prove they were latched.
  task automatic send_frame(input int w, input int h, input bit cap, input int limit,
                            input int en_off_line);
    int   kept;
    exp_t e;
    kept = 0;
    ul1Fval = 1'b1;
    tick(3);
    ulColStart = 12'($urandom); ulColCount = 12'($urandom);
    ulRowStart = 11'($urandom); ulRowCount = 11'($urandom);
    ul2Skip    = 2'($urandom);
    for (int r = 0; r < h; r++) begin
      if (r == en_off_line) ul1Enable = 1'b0;
      for (int c = 0; c < w; c++) begin
        ul1Lval   = 1'b1;
        ulPixData = 12'($urandom);
        if (lat_armed && first_lval_edge < 0) first_lval_edge = cyc + 1;
        if (cap && m_accept(c, r)) begin
          if (kept < limit) begin
            e.data = ulPixData;
            e.sof  = (kept == 0);
            e.eol  = m_eol(c);
            sb.push_back(e);
          end
          kept++;
        end
        tick(1);
      end
      ul1Lval = 1'b0;
      tick(3);
    end
    tick(2);
    ul1Fval = 1'b0;
    apply_cfg();
    tick(4);
    if (cap) exp_fc++;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 300;
    while (sb.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    tick(4);
    check(name, sb.size(), 0);
  endtask

  task automatic monitor();
    exp_t        e;
    bit          hold;
    logic [13:0] hold_v;
    hold = 0;
    hold_v = '0;
    forever begin
      @(negedge ul1Clock);
      if (ul1Reset) begin
        hold = 0;
      end else begin
        if (hold)
          check("hold_stable", {ul1OutValid, ulOutData, ul1OutSof, ul1OutEol}, {1'b1, hold_v});
        hold   = ul1OutValid && !ul1OutReady;
        hold_v = {ulOutData, ul1OutSof, ul1OutEol};
        if (lat_armed && ul1OutValid && first_valid_edge < 0) first_valid_edge = cyc + 1;
        if (ul1OutValid && ul1OutReady) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pixel: got data 0x%0h sof %0b eol %0b expected no transfer",
                     ulOutData, ul1OutSof, ul1OutEol);
          end else begin
            e = sb.pop_front();
            check("pixel{data,sof,eol}", {ulOutData, ul1OutSof, ul1OutEol}, {e.data, e.sof, e.eol});
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    tick(3);
    check("rst_data", ulOutData, 0);
    check("rst_valid", ul1OutValid, 0);
    check("rst_sof", ul1OutSof, 0);
    check("rst_eol", ul1OutEol, 0);
    check("rst_busy", ul1Busy, 0);
    check("rst_frames", ul16FrameCount, 0);
    check("rst_drops", ul16DropCount, 0);
    check("rst_overflow", ul1Overflow, 0);
    ul1Reset = 1'b0;
    tick(2);

    // Full 8x4 frame with latency measurement
    set_cfg(0, 8, 0, 4, 0);
    ul1Enable = 1'b1;
    ul1Continuous = 1'b1;
    tick(2);
    check("busy_waiting", ul1Busy, 1);
    lat_armed = 1;
    send_frame(8, 4, 1, BIG, -1);
    drain("full_frame_drain");
    lat_armed = 0;
    check("latency", first_valid_edge - first_lval_edge, 3);
    check("frames_full", ul16FrameCount, exp_fc);

    // Window 2/4, 1/2 with 2x decimation
    set_cfg(2, 4, 1, 2, 1);
    send_frame(8, 4, 1, BIG, -1);
    drain("window_drain");
    check("frames_window", ul16FrameCount, exp_fc);

    // Random windows/skips with random back-pressure; first one has zero columns
    rand_ready = 1;
    for (int i = 0; i < 5; i++) begin
      set_cfg($urandom_range(0, 3), (i == 0) ? 0 : $urandom_range(0, 5),
              $urandom_range(0, 2), (i == 1) ? 0 : $urandom_range(0, 3), $urandom_range(0, 3));
      send_frame(8, 4, 1, BIG, -1);
    end
    rand_ready = 0;
    ul1OutReady = 1'b1;
    drain("random_drain");
    check("frames_random", ul16FrameCount, exp_fc);
    check("drops_none", ul16DropCount, 0);

    // Overflow: 40 pixels into a 16-entry FIFO with ready held low
    set_cfg(0, 10, 0, 4, 0);
    ul1OutReady = 1'b0;
    send_frame(10, 4, 1, 16, -1);
    check("drops_24", ul16DropCount, 24);
    check("overflow_set", ul1Overflow, 1);
    check("valid_held", ul1OutValid, 1);
    ul1OutReady = 1'b1;
    drain("overflow_drain");

    // Reset mid-frame: buffered pixels flushed, rest of frame ignored
    set_cfg(0, 8, 0, 4, 0);
    ul1OutReady = 1'b0;
    ul1Fval = 1'b1;
    tick(3);
    ul1Lval = 1'b1;
    tick(8);
    ul1Lval = 1'b0;
    tick(3);
    check("prereset_valid", ul1OutValid, 1);
    ul1Reset = 1'b1;
    tick(2);
    check("midrst_valid", ul1OutValid, 0);
    check("midrst_drops", ul16DropCount, 0);
    check("midrst_overflow", ul1Overflow, 0);
    check("midrst_frames", ul16FrameCount, 0);
    exp_fc = 0;
    ul1Reset = 1'b0;
    ul1OutReady = 1'b1;
    for (int r = 0; r < 3; r++) begin
      ul1Lval = 1'b1;
      ulPixData = 12'($urandom);
      tick(8);
      ul1Lval = 1'b0;
      tick(3);
    end
    ul1Fval = 1'b0;
    tick(4);
    check("postrst_frames", ul16FrameCount, 0);
    send_frame(8, 4, 1, BIG, -1);
    drain("postrst_drain");
    check("postrst_frames_after", ul16FrameCount, exp_fc);

    // Single-shot: only the armed frame is captured
    ul1Enable = 1'b0;
    tick(2);
    check("idle_busy", ul1Busy, 0);
    ul1Continuous = 1'b0;
    ul1Enable = 1'b1;
    ul1Arm = 1'b1;
    tick(1);
    ul1Arm = 1'b0;
    tick(2);
    check("armed_busy", ul1Busy, 1);
    send_frame(8, 4, 1, BIG, -1);
    send_frame(8, 4, 0, BIG, -1);
    send_frame(8, 4, 0, BIG, -1);
    drain("single_drain");
    check("single_busy", ul1Busy, 0);
    check("single_frames", ul16FrameCount, exp_fc);

    // Continuous with enable dropped during frame 2
    ul1Continuous = 1'b1;
    tick(2);
    send_frame(8, 4, 1, BIG, -1);
    send_frame(8, 4, 1, BIG, 1);
    send_frame(8, 4, 0, BIG, -1);
    drain("cont_drain");
    check("cont_frames", ul16FrameCount, exp_fc);
    check("cont_busy", ul1Busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
